serial_alu_ctrl: RTL

//  Bit-serial sequencer for the 1-bit add/decrement cell: runs one W-bit
//  op (add, sub, inc, dec) LSB-first, one bit per clock, through the cell.
//  Pre-conditions operand B and initial carry per op, recirculates carry,

---
 rtl/serial_alu_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for an external 1-bit full-adder cell.
// Runs one W-bit add/sub/inc/dec LSB-first, one bit per clock, then
// publishes result and flags together with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one bit per clock through the cell, busy high
// DONE  | result/flags just updated, done high for one cycle
module serial_alu_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         bit_a,
   output logic         bit_b,
   output logic         bit_ci,
   input  logic         bit_o,
   input  logic         bit_co,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         overflow,
   output logic         zero
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   sh_a_q, sh_a_d;
   logic [W-1:0]   sh_b_q, sh_b_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           carry_q, carry_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   result_q, result_d;
   logic           carry_out_q, carry_out_d;
   logic           overflow_q, overflow_d;

   // State and datapath registers; reset abandons any op in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sh_a_q      <= '0;
         sh_b_q      <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_a_q      <= sh_a_d;
         sh_b_q      <= sh_b_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
      end
   end

   // Next-state, operand pre-conditioning, bit stepping and cell drive.
   always_comb begin
      state_d     = state_q;
      sh_a_d      = sh_a_q;
      sh_b_d      = sh_b_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      bit_a       = 1'b0;
      bit_b       = 1'b0;
      bit_ci      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               sh_a_d = a;
               // sub = A + ~B + 1, inc = A + 0 + 1, dec = A + all-ones + 0
               case (op)
                  2'b00:   sh_b_d = b;
                  2'b01:   sh_b_d = ~b;
                  2'b10:   sh_b_d = '0;
                  default: sh_b_d = '1;
               endcase
               carry_d = op[0] ^ op[1];
               sum_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            busy   = 1'b1;
            bit_a  = sh_a_q[0];
            bit_b  = sh_b_q[0];
            bit_ci = carry_q;
            sh_a_d  = sh_a_q >> 1;
            sh_b_d  = sh_b_q >> 1;
            sum_d   = {bit_o, sum_q[W-1:1]};
            carry_d = bit_co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(W-1)) begin
               result_d    = {bit_o, sum_q[W-1:1]};
               carry_out_d = bit_co;
               overflow_d  = carry_q ^ bit_co;
               state_d     = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign zero      = (result_q == '0);

endmodule
